regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter_pkg.sv | 16 +
 rtl/regfile_wb_arbiter_if.sv | 52 +++++
 rtl/regfile_wb_arbiter_wbq_fifo.sv | 82 ++++++++
 rtl/regfile_wb_arbiter.sv | 74 +++++++
 tb/tb_regfile_wb_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and payload types for the register-file writeback arbiter.
// XLEN / RFIDX / WBQ_DEPTH mirror the core-wide defines (data width, register
// index width, default writeback-queue depth).
package regfile_wb_arbiter_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned RFIDX     = 5;
    localparam int unsigned WBQ_DEPTH = 2;

    // One queued long-latency result: destination register and data.
    typedef struct packed {
        logic [RFIDX-1:0] wa;
        logic [XLEN-1:0]  wd;
    } wbq_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the core and the register-file writeback arbiter.
// Carries:
//   pipeline writeback   : pipe_we, pipe_wa, pipe_wd
//   long-latency result  : lu_valid, lu_ready, lu_wa, lu_wd
//   register-file port   : we3, wa3, wd3
//   decode pending query : qa1, qa2 -> pend1, pend2
//   queue status         : empty
// slave  = the arbiter side, master = the core / environment side.
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic             pipe_we;
    logic [RFIDX-1:0] pipe_wa;
    logic [XLEN-1:0]  pipe_wd;

    logic             lu_valid;
    logic             lu_ready;
    logic [RFIDX-1:0] lu_wa;
    logic [XLEN-1:0]  lu_wd;

    logic             we3;
    logic [RFIDX-1:0] wa3;
    logic [XLEN-1:0]  wd3;

    logic [RFIDX-1:0] qa1;
    logic [RFIDX-1:0] qa2;
    logic             pend1;
    logic             pend2;

    logic             empty;

    modport slave (
        input  pipe_we, pipe_wa, pipe_wd,
        input  lu_valid, lu_wa, lu_wd,
        output lu_ready,
        output we3, wa3, wd3,
        input  qa1, qa2,
        output pend1, pend2,
        output empty
    );

    modport master (
        output pipe_we, pipe_wa, pipe_wd,
        output lu_valid, lu_wa, lu_wd,
        input  lu_ready,
        input  we3, wa3, wd3,
        output qa1, qa2,
        input  pend1, pend2,
        input  empty
    );

endinterface

// File: rtl/regfile_wb_arbiter_wbq_fifo.sv
// Writeback queue for long-latency results.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   i_push, i_entry   : enqueue one entry (caller guarantees not full)
//   i_pop             : dequeue the head (caller guarantees not empty)
//   o_head            : current head entry
//   o_full, o_empty   : occupancy status
//   i_qa1/i_qa2       : register queries; o_pend1/o_pend2 flag a stored match
module regfile_wb_arbiter_wbq_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = WBQ_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  wbq_entry_t       i_entry,
    input  logic             i_pop,
    input  logic [RFIDX-1:0] i_qa1,
    input  logic [RFIDX-1:0] i_qa2,
    output wbq_entry_t       o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_pend1,
    output logic             o_pend2
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    wbq_entry_t       r_mem [DEPTH];

    logic             w_hit1;
    logic             w_hit2;
    logic [PTR_W-1:0] w_idx;

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Data storage is left unreset; only occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_entry;
    end

    // Compare every occupied slot (head onward) against both queries.
    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        w_idx  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_idx = r_rd_ptr + PTR_W'(k);
            if (CNT_W'(k) < r_count) begin
                if (r_mem[w_idx].wa == i_qa1) w_hit1 = 1'b1;
                if (r_mem[w_idx].wa == i_qa2) w_hit2 = 1'b1;
            end
        end
    end

    assign o_pend1 = w_hit1 && (i_qa1 != '0);
    assign o_pend2 = w_hit2 && (i_qa2 != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register-file write port, merging the non-stallable pipeline
// writeback with queued long-latency results.
// Ports:
//   clk    : core clock
//   reset  : synchronous active-high reset
//   bus    : writeback bus (slave side): pipeline writeback, long-latency
//            valid/ready handshake, register-file write port, decode pending
//            queries and queue-empty status
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = WBQ_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_wb_arbiter_if.slave   bus
);

    wbq_entry_t w_push_entry;
    wbq_entry_t w_head;
    logic       w_push;
    logic       w_pop;
    logic       w_pipe_win;
    logic       w_full;
    logic       w_empty;

    // Ready comes from stored occupancy only, so no path from lu_valid.
    assign bus.lu_ready = !w_full;
    assign bus.empty    = w_empty;

    // Results for x0 complete the handshake but are never stored.
    assign w_push            = bus.lu_valid && !w_full && (bus.lu_wa != '0);
    assign w_push_entry.wa   = bus.lu_wa;
    assign w_push_entry.wd   = bus.lu_wd;

    // Pipeline writes to x0 do not claim the port.
    assign w_pipe_win = bus.pipe_we && (bus.pipe_wa != '0);

    // Write-port arbitration: pipeline first, then the queue head.
    always_comb begin
        bus.we3 = 1'b0;
        bus.wa3 = '0;
        bus.wd3 = '0;
        w_pop   = 1'b0;
        if (w_pipe_win) begin
            bus.we3 = 1'b1;
            bus.wa3 = bus.pipe_wa;
            bus.wd3 = bus.pipe_wd;
        end else if (!w_empty) begin
            bus.we3 = 1'b1;
            bus.wa3 = w_head.wa;
            bus.wd3 = w_head.wd;
            w_pop   = 1'b1;
        end
    end

    regfile_wb_arbiter_wbq_fifo #(
        .DEPTH (DEPTH)
    ) u_wbq (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .i_qa1   (bus.qa1),
        .i_qa2   (bus.qa2),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_pend1 (bus.pend1),
        .o_pend2 (bus.pend2)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int unsigned TB_DEPTH = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus();

    regfile_wb_arbiter #(.DEPTH(TB_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: ordered list of stored results.
    wbq_entry_t mq[$];

    logic             exp_ready, exp_empty, exp_we, exp_p1, exp_p2;
    logic [RFIDX-1:0] exp_wa;
    logic [XLEN-1:0]  exp_wd;

    task automatic model_eval();
        exp_ready = (mq.size() != TB_DEPTH);
        exp_empty = (mq.size() == 0);
        exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
        if (bus.pipe_we && bus.pipe_wa != 0) begin
            exp_we = 1'b1; exp_wa = bus.pipe_wa; exp_wd = bus.pipe_wd;
        end else if (mq.size() > 0) begin
            exp_we = 1'b1; exp_wa = mq[0].wa; exp_wd = mq[0].wd;
        end
        exp_p1 = 1'b0; exp_p2 = 1'b0;
        foreach (mq[k]) begin
            if (bus.qa1 != 0 && mq[k].wa == bus.qa1) exp_p1 = 1'b1;
            if (bus.qa2 != 0 && mq[k].wa == bus.qa2) exp_p2 = 1'b1;
        end
    endtask

    task automatic drive(input logic pwe, input logic [RFIDX-1:0] pwa, input logic [XLEN-1:0] pwd,
                         input logic lv, input logic [RFIDX-1:0] lwa, input logic [XLEN-1:0] lwd,
                         input logic [RFIDX-1:0] q1, input logic [RFIDX-1:0] q2);
        @(negedge clk);
        bus.pipe_we = pwe; bus.pipe_wa = pwa; bus.pipe_wd = pwd;
        bus.lu_valid = lv; bus.lu_wa = lwa; bus.lu_wd = lwd;
        bus.qa1 = q1; bus.qa2 = q2;
        #1;
        model_eval();
    endtask

    // Advance one clock and apply the same clock's effect to the model.
    task automatic tick();
        logic do_pop, do_push;
        wbq_entry_t e;
        model_eval();
        do_pop  = !(bus.pipe_we && bus.pipe_wa != 0) && (mq.size() > 0);
        do_push = bus.lu_valid && exp_ready && (bus.lu_wa != 0);
        e.wa = bus.lu_wa; e.wd = bus.lu_wd;
        @(posedge clk);
        if (reset) mq.delete();
        else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
    endtask

    task automatic idle(input logic [RFIDX-1:0] q1, input logic [RFIDX-1:0] q2);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, q1, q2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(5'd5, 5'd0); tick();
        idle(5'd5, 5'd0); reset = 1'b0;
        n_cmp++; if (bus.we3 !== 1'b0) begin n_err++; $display("FAIL reset_we3: got %b want 0", bus.we3); end
        n_cmp++; if (bus.lu_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.lu_ready); end
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        n_cmp++; if (bus.pend1 !== 1'b0) begin n_err++; $display("FAIL reset_pend1: got %b want 0", bus.pend1); end
        tick();
    endtask

    task automatic test_single();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd0);
        n_cmp++; if (bus.we3 !== 1'b0) begin n_err++; $display("FAIL single_nobypass: got we3=%b want 0", bus.we3); end
        n_cmp++; if (bus.pend1 !== 1'b0) begin n_err++; $display("FAIL single_pend_early: got %b want 0", bus.pend1); end
        tick();
        idle(5'd7, 5'd0);
        n_cmp++; if (bus.we3 !== 1'b1 || bus.wa3 !== 5'd7 || bus.wd3 !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL single_write: got we3=%b wa3=%0d wd3=%h want 1/7/deadbeef", bus.we3, bus.wa3, bus.wd3); end
        n_cmp++; if (bus.pend1 !== 1'b1) begin n_err++; $display("FAIL single_pend: got %b want 1", bus.pend1); end
        tick();
        idle(5'd7, 5'd0);
        n_cmp++; if (bus.empty !== 1'b1 || bus.pend1 !== 1'b0 || bus.we3 !== 1'b0) begin
            n_err++; $display("FAIL single_after: got empty=%b pend1=%b we3=%b want 1/0/0", bus.empty, bus.pend1, bus.we3); end
        tick();
    endtask

    task automatic test_pipe_priority();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd3, 32'(100 + i), (i < 2), (i == 0) ? 5'd8 : 5'd9,
                  (i == 0) ? 32'h11 : 32'h22, 5'd8, 5'd9);
            n_cmp++; if (bus.we3 !== 1'b1 || bus.wa3 !== 5'd3 || bus.wd3 !== 32'(100 + i)) begin
                n_err++; $display("FAIL prio_pipe[%0d]: got we3=%b wa3=%0d wd3=%0d want 1/3/%0d", i, bus.we3, bus.wa3, bus.wd3, 100 + i); end
            n_cmp++; if (bus.lu_ready !== (i < 2)) begin
                n_err++; $display("FAIL prio_ready[%0d]: got %b want %b", i, bus.lu_ready, (i < 2)); end
            tick();
        end
        idle(5'd8, 5'd9);
        n_cmp++; if (bus.we3 !== 1'b1 || bus.wa3 !== 5'd8 || bus.wd3 !== 32'h11 || bus.lu_ready !== 1'b0) begin
            n_err++; $display("FAIL prio_drain0: got we3=%b wa3=%0d wd3=%h ready=%b want 1/8/11/0", bus.we3, bus.wa3, bus.wd3, bus.lu_ready); end
        tick();
        idle(5'd8, 5'd9);
        n_cmp++; if (bus.we3 !== 1'b1 || bus.wa3 !== 5'd9 || bus.wd3 !== 32'h22 || bus.lu_ready !== 1'b1) begin
            n_err++; $display("FAIL prio_drain1: got we3=%b wa3=%0d wd3=%h ready=%b want 1/9/22/1", bus.we3, bus.wa3, bus.wd3, bus.lu_ready); end
        n_cmp++; if (bus.pend1 !== 1'b0 || bus.pend2 !== 1'b1) begin
            n_err++; $display("FAIL prio_pend: got pend1=%b pend2=%b want 0/1", bus.pend1, bus.pend2); end
        tick();
        idle(5'd0, 5'd0);
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL prio_empty: got %b want 1", bus.empty); end
        tick();
    endtask

    task automatic test_x0_drop();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 5'd0, 5'd0);
        n_cmp++; if (bus.lu_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready: got %b want 1", bus.lu_ready); end
        tick();
        idle(5'd0, 5'd0);
        n_cmp++; if (bus.empty !== 1'b1 || bus.we3 !== 1'b0) begin
            n_err++; $display("FAIL x0_dropped: got empty=%b we3=%b want 1/0", bus.empty, bus.we3); end
        tick();
    endtask

    task automatic test_full_pipe_x0();
        drive(1'b1, 5'd3, 32'd1, 1'b1, 5'd10, 32'hA, 5'd10, 5'd11); tick();
        drive(1'b1, 5'd3, 32'd2, 1'b1, 5'd11, 32'hB, 5'd10, 5'd11); tick();
        drive(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 5'd10, 5'd11);
        n_cmp++; if (bus.lu_ready !== 1'b0 || bus.pend1 !== 1'b1 || bus.pend2 !== 1'b1) begin
            n_err++; $display("FAIL full_state: got ready=%b pend1=%b pend2=%b want 0/1/1", bus.lu_ready, bus.pend1, bus.pend2); end
        n_cmp++; if (bus.we3 !== 1'b1 || bus.wa3 !== 5'd10 || bus.wd3 !== 32'hA) begin
            n_err++; $display("FAIL full_x0_head: got we3=%b wa3=%0d wd3=%h want 1/10/a", bus.we3, bus.wa3, bus.wd3); end
        tick();
        drive(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 5'd10, 5'd11);
        n_cmp++; if (bus.lu_ready !== 1'b1 || bus.wa3 !== 5'd11 || bus.wd3 !== 32'hB || bus.pend1 !== 1'b0) begin
            n_err++; $display("FAIL full_x0_next: got ready=%b wa3=%0d wd3=%h pend1=%b want 1/11/b/0", bus.lu_ready, bus.wa3, bus.wd3, bus.pend1); end
        tick();
    endtask

    task automatic test_full_blocked();
        drive(1'b1, 5'd3, 32'd1, 1'b1, 5'd13, 32'hD, 5'd12, 5'd0); tick();
        drive(1'b1, 5'd3, 32'd2, 1'b1, 5'd14, 32'hE, 5'd12, 5'd0); tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC, 5'd12, 5'd0);
        n_cmp++; if (bus.lu_ready !== 1'b0 || bus.wa3 !== 5'd13) begin
            n_err++; $display("FAIL blocked_full: got ready=%b wa3=%0d want 0/13", bus.lu_ready, bus.wa3); end
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC, 5'd12, 5'd0);
        n_cmp++; if (bus.lu_ready !== 1'b1 || bus.wa3 !== 5'd14 || bus.pend1 !== 1'b0) begin
            n_err++; $display("FAIL blocked_retry: got ready=%b wa3=%0d pend1=%b want 1/14/0", bus.lu_ready, bus.wa3, bus.pend1); end
        tick();
        idle(5'd12, 5'd0);
        n_cmp++; if (bus.wa3 !== 5'd12 || bus.wd3 !== 32'hC || bus.pend1 !== 1'b1) begin
            n_err++; $display("FAIL blocked_drain: got wa3=%0d wd3=%h pend1=%b want 12/c/1", bus.wa3, bus.wd3, bus.pend1); end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 5'd3, 32'd1, 1'b1, 5'd20, 32'h20, 5'd20, 5'd21); tick();
        drive(1'b1, 5'd3, 32'd2, 1'b1, 5'd21, 32'h21, 5'd20, 5'd21); tick();
        idle(5'd20, 5'd21); reset = 1'b1; tick();
        idle(5'd20, 5'd21); reset = 1'b0;
        n_cmp++; if (bus.we3 !== 1'b0 || bus.empty !== 1'b1 || bus.lu_ready !== 1'b1) begin
            n_err++; $display("FAIL midreset_state: got we3=%b empty=%b ready=%b want 0/1/1", bus.we3, bus.empty, bus.lu_ready); end
        n_cmp++; if (bus.pend1 !== 1'b0 || bus.pend2 !== 1'b0) begin
            n_err++; $display("FAIL midreset_pend: got pend1=%b pend2=%b want 0/0", bus.pend1, bus.pend2); end
        tick();
        idle(5'd0, 5'd0);
        n_cmp++; if (bus.we3 !== 1'b0) begin n_err++; $display("FAIL midreset_nowrite: got we3=%b want 0", bus.we3); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), 32'($urandom),
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 32'($urandom),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            reset = ($urandom_range(0, 63) == 0);
            n_cmp++; if (bus.lu_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, bus.lu_ready, exp_ready); end
            n_cmp++; if (bus.empty !== exp_empty) begin n_err++; $display("FAIL rnd_empty[%0d]: got %b want %b", c, bus.empty, exp_empty); end
            n_cmp++; if (bus.we3 !== exp_we) begin n_err++; $display("FAIL rnd_we3[%0d]: got %b want %b", c, bus.we3, exp_we); end
            n_cmp++; if (bus.wa3 !== exp_wa) begin n_err++; $display("FAIL rnd_wa3[%0d]: got %0d want %0d", c, bus.wa3, exp_wa); end
            n_cmp++; if (bus.wd3 !== exp_wd) begin n_err++; $display("FAIL rnd_wd3[%0d]: got %h want %h", c, bus.wd3, exp_wd); end
            n_cmp++; if (bus.pend1 !== exp_p1) begin n_err++; $display("FAIL rnd_pend1[%0d]: got %b want %b", c, bus.pend1, exp_p1); end
            n_cmp++; if (bus.pend2 !== exp_p2) begin n_err++; $display("FAIL rnd_pend2[%0d]: got %b want %b", c, bus.pend2, exp_p2); end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.pipe_we = 1'b0; bus.pipe_wa = '0; bus.pipe_wd = '0;
        bus.lu_valid = 1'b0; bus.lu_wa = '0; bus.lu_wd = '0;
        bus.qa1 = '0; bus.qa2 = '0;
        test_reset();
        test_single();
        test_pipe_priority();
        test_x0_drop();
        test_full_pipe_x0();
        test_full_blocked();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
